counter_ctrl: RTL



---
 rtl/counter_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/counter_ctrl.sv
// counter_ctrl: run controller for a WIDTH-bit synchronous up-counter.
// It drives the counter's enable and active-low synchronous clear and watches
// q. It supports a programmable terminal count, one-shot and periodic modes,
// a repeat count, pause/stop, and done/wrap status pulses.
// Optional feature macro: CNT_CTRL_IRQ_EN adds irq_clr/irq. irq is a sticky
// interrupt that is set by done.
module counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_periodic,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_clr_n,
    output logic             busy,
    output logic             done,
    output logic             wrap,
`ifdef CNT_CTRL_IRQ_EN
    input  logic             irq_clr,
    output logic             irq,
`endif
    output logic [REP_W-1:0] rep_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_limit;
    logic             r_periodic;
    logic [REP_W-1:0] r_reps;
    logic [REP_W-1:0] r_rep_cnt;
    logic             r_done;
    logic             r_wrap;
    logic             r_busy;

    logic w_cfg_xfer;
    logic w_term;
    logic w_run_go;
    logic w_term_act;
    logic w_last_rep;

    // Decode the handshake, the terminal condition and the stop > pause > term priority.
    always_comb begin
        cfg_ready  = (r_state == ST_IDLE);
        w_cfg_xfer = cfg_valid && cfg_ready;
        w_term     = (cnt_q == r_limit);
        w_run_go   = (r_state == ST_RUN) && !stop && !pause;
        w_term_act = w_run_go && w_term;
        w_last_rep = (r_reps != '0) && ((r_rep_cnt + REP_W'(1)) == r_reps);
        // The counter is enabled only while running below the limit. The
        // counter is cleared during CLEAR and on every periodic wrap.
        cnt_en     = w_run_go && !w_term;
        cnt_clr_n  = !((r_state == ST_CLEAR) || (w_term_act && r_periodic));
    end

    // Latch the configuration on an accepted offer. The offer can only be
    // accepted in IDLE.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_limit    <= '1;
            r_periodic <= 1'b0;
            r_reps     <= '0;
        end else if (w_cfg_xfer) begin
            r_limit    <= cfg_limit;
            r_periodic <= cfg_periodic;
            r_reps     <= cfg_reps;
        end
    end

    // Run FSM with registered busy/done/wrap and the completed-period counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rep_cnt <= '0;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_rep_cnt <= '0;
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_term_act) begin
                        if (r_periodic) begin
                            r_rep_cnt <= r_rep_cnt + REP_W'(1);
                            r_wrap    <= 1'b1;
                            if (w_last_rep) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign wrap    = r_wrap;
    assign rep_cnt = r_rep_cnt;

`ifdef CNT_CTRL_IRQ_EN
    logic r_irq;

    // Sticky interrupt. It is set by the visible done pulse, and the set wins
    // over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if (r_done) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`endif

endmodule
